// File: rtl/imul_pkg.sv
// Shared constants and state encoding for the radix-4 iterative multiplier scheduler.
package imul_pkg;

    localparam int IMUL_DATA_WIDTH = 16;
    localparam int IMUL_NUM_ITER   = IMUL_DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imul_sched_mux4x1.sv
// Four-input selector used to pick the radix-4 partial product (0, A, 2A, 3A).
module MUX4X1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out_y
);

    always_comb begin
        out_y = in0;
        case (sel)
            2'd0:    out_y = in0;
            2'd1:    out_y = in1;
            2'd2:    out_y = in2;
            default: out_y = in3;
        endcase
    end

endmodule

// File: rtl/imul_sched.sv
// Two-requester round-robin front end for a shared radix-4 iterative unsigned multiplier.
module imul_sched
    import imul_pkg::*;
#(
    parameter int DATA_WIDTH = IMUL_DATA_WIDTH,
    parameter int NUM_ITER   = DATA_WIDTH / 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iReq0,
    input  logic                    iReq1,
    input  logic [DATA_WIDTH-1:0]   iA0,
    input  logic [DATA_WIDTH-1:0]   iB0,
    input  logic [DATA_WIDTH-1:0]   iA1,
    input  logic [DATA_WIDTH-1:0]   iB1,
    output logic                    oAck0,
    output logic                    oAck1,
    output logic                    oValid,
    output logic [2*DATA_WIDTH-1:0] oResult,
    output logic                    oOwner,
    output logic                    oBusy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(NUM_ITER - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]         acc_q, acc_d, result_q, result_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  gnt_q, gnt_d, last_q, last_d, owner_q, owner_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d, valid_q, valid_d;
    logic                  grant;
    logic [PW-1:0]         a_ext, a_x2, a_x3, pp;
    logic [1:0]            digit;

    assign a_ext = {{DATA_WIDTH{1'b0}}, a_q};
    assign a_x2  = a_ext << 1;
    assign a_x3  = a_x2 + a_ext;
    assign digit = b_q[{cnt_q, 1'b0} +: 2];

    MUX4X1 #(.WIDTH(PW)) u_pp_mux (
        .in0   ('0),
        .in1   (a_ext),
        .in2   (a_x2),
        .in3   (a_x3),
        .sel   (digit),
        .out_y (pp)
    );

    // Result and valid are loaded on the final CALC edge so they are visible during DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        result_d = result_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        valid_d  = 1'b0;
        grant    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iReq0 || iReq1) begin
                    grant   = (iReq0 && iReq1) ? ~last_q : iReq1;
                    gnt_d   = grant;
                    last_d  = grant;
                    a_d     = grant ? iA1 : iA0;
                    b_d     = grant ? iB1 : iB0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + (pp << {cnt_q, 1'b0});
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_K) begin
                    result_d = acc_d;
                    owner_d  = gnt_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            result_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            valid_q  <= valid_d;
        end
    end

    assign oAck0   = ack0_q;
    assign oAck1   = ack1_q;
    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oOwner  = owner_q;
    assign oBusy   = (state_q != IDLE);

endmodule

// File: doc/imul_sched.md
IMUL_SCHED -- requirements
Module: imul_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, operand width (even; result width 2*DATA_WIDTH).
REQ-002 The block SHALL have parameter NUM_ITER, default DATA_WIDTH/2, radix-4 iterations per product.
REQ-003 Port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port Reset  input  1  synchronous, active-low reset.
REQ-005 Port iReq0 / iReq1  input  1 each  multiply request from requester 0 / 1.
REQ-006 Port iA0, iB0 / iA1, iB1  input  DATA_WIDTH each  unsigned multiplicand / multiplier per requester.
REQ-007 Port oAck0 / oAck1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 Port oValid  output  1  one-cycle result-valid pulse.
REQ-009 Port oResult  output  2*DATA_WIDTH  unsigned product.
REQ-010 Port oOwner  output  1  requester index of oResult.
REQ-011 Port oBusy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE.
REQ-013 IDLE: if any iReqN is high, the block SHALL grant one requester, latch its A/B, clear accumulator and iteration counter, pulse the matching oAckN in the next cycle, and go to CALC.
REQ-014 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; with one request, grant it.
REQ-015 CALC: each cycle, digit d = B[2k+1:2k] (k = counter) SHALL select partial product 0, A, 2A or 3A, and accumulator SHALL add it shifted left by 2k.
REQ-016 After NUM_ITER CALC cycles (k = NUM_ITER-1 processed), the FSM SHALL go to DONE.
REQ-017 DONE: oResult SHALL load the accumulator, oOwner the granted index, oValid SHALL be high for exactly that one cycle, then FSM returns to IDLE.
REQ-018 Latency: oValid SHALL assert exactly NUM_ITER cycles after the oAckN cycle (8 for default); a new grant SHALL occur no earlier than the cycle after DONE (10-cycle minimum issue interval).
REQ-019 Requests SHALL be ignored outside IDLE; a requester SHALL drop iReqN in its oAckN cycle, else a new request is seen on return to IDLE.
REQ-020 oResult and oOwner SHALL hold their value until the next DONE.
REQ-021 Accumulator SHALL be 2*DATA_WIDTH bits; no overflow possible (max 0xFFFF*0xFFFF = 0xFFFE0001).
REQ-022 The last-served pointer SHALL update on grant.

Reset
REQ-023 Reset low on a clock edge SHALL force IDLE, counter 0, accumulator 0, oResult 0, oOwner 0, oValid 0, oAck0/1 0, oBusy 0, last-served = 1 (requester 0 wins first tie).
REQ-024 Reset mid-CALC SHALL abort the operation with no oValid pulse and no oResult update.

Structure
REQ-025 Shared package imul_pkg SHALL hold DATA_WIDTH default, NUM_ITER, and the state encoding constants.
REQ-026 Partial-product selection SHALL reuse the existing MUX4X1 sub-module (one instance, inputs 0, A, 2A, 3A zero-extended to 2*DATA_WIDTH).

Verification
REQ-027 Req0 only, A=0x0003, B=0x0005 -> oAck0 next cycle, oValid 8 cycles later, oResult=0x0000000F, oOwner=0.
REQ-028 Req1 only, A=0xFFFF, B=0xFFFF -> oResult=0xFFFE0001, oOwner=1.
REQ-029 Both requests held high after reset, A0=2,B0=3, A1=4,B1=5 -> grants 0 then 1; results 0x6 (owner 0) then 0x14 (owner 1); second oAck1 no earlier than cycle after first oValid.
REQ-030 A=0x1234, B=0x0000 and A=0x0000, B=0xABCD -> oResult=0 both, full 8-cycle latency.
REQ-031 Reset low during CALC iteration 4 -> no oValid, oResult stays 0, oBusy 0; next request completes correctly.
REQ-032 Random 1000 operand pairs, random requests -> every oResult equals A*B, owners alternate under contention.
